// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC sample capture writer.
// Samples are 12-bit unsigned values packed two per 32-bit RAM word.
package adc_capture_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CHAN_W   = 5;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_LOW  = 4'h3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  // Each sample is zero-extended into its own 16-bit half of the word.
  function automatic logic [31:0] pack_word(input logic [SAMPLE_W-1:0] hi,
                                            input logic [SAMPLE_W-1:0] lo);
    return {{(16-SAMPLE_W){1'b0}}, hi, {(16-SAMPLE_W){1'b0}}, lo};
  endfunction

endpackage

// File: rtl/adc_level_trigger.sv
// Rising-edge level trigger: remembers the previous matching sample and fires
// when the stream crosses from below the level to at-or-above it.
module adc_level_trigger
  import adc_capture_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] data,
  input  logic [SAMPLE_W-1:0] level,
  output logic                fire
);

  logic                prev_valid;
  logic [SAMPLE_W-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_valid <= 1'b0;
      prev       <= '0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (sample_en) begin
      prev_valid <= 1'b1;
      prev       <= data;
    end
  end

  // The first sample after arming has no predecessor and can never fire.
  assign fire = sample_en && prev_valid && (prev < level) && (data >= level);

endmodule

// File: rtl/adc_sample_capture_writer.sv
// Filters the ADC stream to one channel, optionally waits for a level trigger,
// packs sample pairs into 32-bit words and writes them to the sample RAM.
module adc_sample_capture_writer
  import adc_capture_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int BASE_WORD = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic                cfg_circular,
  input  logic [CHAN_W-1:0]   cfg_channel,
  input  logic                cfg_trig_en,
  input  logic [SAMPLE_W-1:0] cfg_trig_level,
  input  logic                smp_valid,
  input  logic [CHAN_W-1:0]   smp_channel,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [3:0]          mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [31:0]         mem_writedata,
  output logic                mem_clken,
  output logic                busy,
  output logic                done,
  output logic                wrapped,
  output logic [ADDR_W:0]     words_written,
  output logic [1:0]          dbg_state
);

  // Handshake: the sample stream has no backpressure; a sample is consumed on
  // any edge where smp_valid=1 and its channel matches. RAM writes are single
  // cycle strobes with no waitrequest.

  localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic                circ_q;
  logic [CHAN_W-1:0]   chan_q;
  logic [SAMPLE_W-1:0] level_q;
  logic [SAMPLE_W-1:0] half_data;
  logic                half_valid;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     lap_cnt;

  logic [ADDR_W:0] len_eff;
  logic            accept;
  logic            trig_fire;
  logic            arm;
  logic            do_full;
  logic            do_flush;
  logic            len_hit;

  assign len_eff  = (len_q == '0) ? LEN_DEPTH : len_q;
  assign accept   = smp_valid && (smp_channel == chan_q);
  assign arm      = (state == IDLE) && start;
  assign do_full  = (state == CAPTURE) && accept && half_valid;
  assign do_flush = (state == FLUSH);
  assign len_hit  = ((lap_cnt + CNT_ONE) == len_eff);

  assign mem_clken = 1'b1;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  adc_level_trigger u_trig (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (arm),
    .sample_en ((state == WAIT_TRIG) && accept),
    .data      (smp_data),
    .level     (level_q),
    .fire      (trig_fire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      len_q          <= '0;
      circ_q         <= 1'b0;
      chan_q         <= '0;
      level_q        <= '0;
      half_data      <= '0;
      half_valid     <= 1'b0;
      addr           <= BASE_ADDR;
      lap_cnt        <= '0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      done           <= 1'b0;
      wrapped        <= 1'b0;
      words_written  <= '0;
    end else begin
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_byteenable <= '0;
      done           <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            len_q         <= cfg_len;
            circ_q        <= cfg_circular;
            chan_q        <= cfg_channel;
            level_q       <= cfg_trig_level;
            half_valid    <= 1'b0;
            addr          <= BASE_ADDR;
            lap_cnt       <= '0;
            words_written <= '0;
            wrapped       <= 1'b0;
            state         <= cfg_trig_en ? WAIT_TRIG : CAPTURE;
          end
        end
        WAIT_TRIG: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (trig_fire) begin
            half_data  <= smp_data;
            half_valid <= 1'b1;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          // A sample arriving with stop is consumed before stop is acted on.
          if (do_full) begin
            half_valid <= 1'b0;
            if ((len_hit && !circ_q) || stop) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end else if (accept) begin
            half_data  <= smp_data;
            half_valid <= 1'b1;
            if (stop) state <= FLUSH;
          end else if (stop) begin
            if (half_valid) begin
              state <= FLUSH;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          half_valid <= 1'b0;
          state      <= IDLE;
          done       <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (do_full || do_flush) begin
        mem_write      <= 1'b1;
        mem_chipselect <= 1'b1;
        mem_address    <= addr;
        mem_byteenable <= do_flush ? BE_LOW : BE_FULL;
        mem_writedata  <= do_flush ? pack_word('0, half_data)
                                   : pack_word(smp_data, half_data);
        if (words_written != len_eff) words_written <= words_written + CNT_ONE;
        // End of a lap: linear captures stop here, circular ones restart at the base.
        if (len_hit) begin
          lap_cnt <= '0;
          addr    <= BASE_ADDR;
          if (circ_q) wrapped <= 1'b1;
        end else begin
          lap_cnt <= lap_cnt + CNT_ONE;
          addr    <= addr + ADDR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_capture_writer.sv
// Self-checking bench: directed capture scenarios plus randomized captures
// compared against a sample-list reference model of the capture rules.
module tb_adc_sample_capture_writer;

  localparam int ADDR_W    = 13;
  localparam int DEPTH     = 8192;
  localparam int BASE_WORD = 0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [ADDR_W:0]   cfg_len = '0;
  logic              cfg_circular = 1'b0;
  logic [4:0]        cfg_channel = '0;
  logic              cfg_trig_en = 1'b0;
  logic [11:0]       cfg_trig_level = '0;
  logic              smp_valid = 1'b0;
  logic [4:0]        smp_channel = '0;
  logic [11:0]       smp_data = '0;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [ADDR_W:0]   words_written;
  logic [1:0]        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  adc_sample_capture_writer #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_WORD(BASE_WORD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_circular(cfg_circular), .cfg_channel(cfg_channel),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_level(cfg_trig_level),
    .smp_valid(smp_valid), .smp_channel(smp_channel), .smp_data(smp_data),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .busy(busy),
    .done(done), .wrapped(wrapped), .words_written(words_written),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected write record: {address, byteenable, data}.
  logic [48:0] exp_q[$];
  logic        exp_done_q[$];

  bit          m_busy, m_wait, m_flush, m_pend, m_has_prev, m_circ;
  logic [11:0] m_half, m_prev, m_level;
  logic [4:0]  m_ch;
  int          m_len, m_k, exp_ww;
  bit          exp_wrapped;

  task automatic emit(input logic [3:0] be, input logic [31:0] d);
    int off;
    logic [ADDR_W-1:0] a;
    off = m_circ ? (m_k % m_len) : m_k;
    a = ADDR_W'((BASE_WORD + off) % DEPTH);
    exp_q.push_back({a, be, d});
    m_k++;
    exp_ww = (m_k < m_len) ? m_k : m_len;
    if (m_circ && m_k >= m_len) exp_wrapped = 1'b1;
  endtask

  task automatic finish_capture(input bit with_write);
    m_busy = 1'b0;
    exp_done_q.push_back(with_write);
  endtask

  task automatic model(input logic st, input logic sp, input logic v,
                       input logic [4:0] ch, input logic [11:0] d);
    bit match, ended;
    match = v && (ch == m_ch);
    if (!m_busy) begin
      if (st) begin
        m_busy = 1'b1; m_wait = cfg_trig_en; m_flush = 1'b0; m_pend = 1'b0;
        m_has_prev = 1'b0; m_k = 0; exp_ww = 0; exp_wrapped = 1'b0;
        m_len = (cfg_len == '0) ? DEPTH : int'(cfg_len);
        m_circ = cfg_circular; m_ch = cfg_channel; m_level = cfg_trig_level;
      end
    end else if (m_flush) begin
      emit(4'h3, {20'h0, m_half});
      m_flush = 1'b0; m_pend = 1'b0;
      finish_capture(1'b1);
    end else if (m_wait) begin
      if (sp) finish_capture(1'b0);
      else if (match) begin
        if (m_has_prev && m_prev < m_level && d >= m_level) begin
          m_wait = 1'b0; m_pend = 1'b1; m_half = d;
        end
        m_prev = d; m_has_prev = 1'b1;
      end
    end else begin
      ended = 1'b0;
      if (match) begin
        if (m_pend) begin
          emit(4'hF, {4'h0, d, 4'h0, m_half});
          m_pend = 1'b0;
          if (!m_circ && m_k == m_len) ended = 1'b1;
        end else begin
          m_pend = 1'b1; m_half = d;
        end
      end
      if (!ended && sp) begin
        if (m_pend) m_flush = 1'b1;
        else ended = 1'b1;
      end
      if (ended) finish_capture(match && !m_pend);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_done_q.delete();
    m_busy = 1'b0; m_flush = 1'b0; m_pend = 1'b0; m_wait = 1'b0;
    exp_ww = 0; exp_wrapped = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_write) begin
        if (exp_q.size() == 0) check("unexpected_wr", 64'd1, 64'd0);
        else check("wr", {mem_chipselect, mem_address, mem_byteenable, mem_writedata},
                   {1'b1, exp_q.pop_front()});
      end else begin
        check("cs_idle", mem_chipselect, 1'b0);
      end
      if (done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("done_with_wr", mem_write, exp_done_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic st, input logic sp, input logic v,
                      input logic [4:0] ch, input logic [11:0] d);
    start = st; stop = sp; smp_valid = v; smp_channel = ch; smp_data = d;
    model(st, sp, v, ch, d);
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; smp_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 12'd0);
  endtask

  task automatic end_check(input string tag);
    idle(3);
    check({tag, "_exp_left"}, exp_q.size(), 0);
    check({tag, "_done_left"}, exp_done_q.size(), 0);
    check({tag, "_ww"}, words_written, exp_ww);
    check({tag, "_wrapped"}, wrapped, exp_wrapped);
    check({tag, "_busy"}, busy, m_busy);
  endtask

  task automatic set_cfg(input int len, input bit circ, input logic [4:0] ch,
                         input bit trig, input logic [11:0] lvl);
    cfg_len = (ADDR_W+1)'(len); cfg_circular = circ; cfg_channel = ch;
    cfg_trig_en = trig; cfg_trig_level = lvl;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_be"}, mem_byteenable, 0);
    check({tag, "_cs"}, mem_chipselect, 0);
    check({tag, "_wr"}, mem_write, 0);
    check({tag, "_wdata"}, mem_writedata, 0);
    check({tag, "_clken"}, mem_clken, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wrapped"}, wrapped, 0);
    check({tag, "_ww"}, words_written, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset_n = 1'b1;
    idle(2);

    // Linear capture of two words with back-to-back samples.
    set_cfg(2, 0, 5'd3, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 1, 5'd3, 12'(i));
    check("t1_done", done, 1);
    check("t1_wdata", mem_writedata, 32'h00040003);
    step(0, 0, 0, 0, 0);
    check("t1_busy_after", busy, 0);
    end_check("t1");

    // Channel filter with interleaved channels.
    set_cfg(3, 0, 5'd3, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      step(0, 0, 1, (i % 2 == 0) ? 5'd1 : 5'd3, 12'($urandom_range(0, 4095)));
    step(0, 1, 0, 0, 0);
    end_check("t2");

    // Level trigger.
    set_cfg(1, 0, 5'd0, 1, 12'h800);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 5'd0, 12'h100);
    step(0, 0, 1, 5'd0, 12'h7FF);
    step(0, 0, 1, 5'd0, 12'h800);
    step(0, 0, 1, 5'd0, 12'h900);
    check("t3_wdata", mem_writedata, 32'h09000800);
    end_check("t3");

    // Circular buffer with 8 pairs over a 3-word ring.
    set_cfg(3, 1, 5'd2, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 5'd2, 12'(16 + i));
    step(0, 1, 0, 0, 0);
    check("t4_wrapped", wrapped, 1);
    check("t4_ww", words_written, 3);
    end_check("t4");

    // Stop with a half word pending forces a low-half flush.
    set_cfg(0, 0, 5'd4, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 5'd4, 12'hA);
    step(0, 0, 1, 5'd4, 12'hB);
    step(0, 0, 1, 5'd4, 12'hC);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t5_flush_be", mem_byteenable, 4'h3);
    check("t5_flush_data", mem_writedata, 32'h0000000C);
    end_check("t5");

    // Asynchronous reset in the middle of a capture.
    set_cfg(4, 0, 5'd5, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 5'd5, 12'h123);
    reset_n = 1'b0;
    #2;
    check_reset_outputs("t6_rst");
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    set_cfg(1, 0, 5'd5, 0, 12'h0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 5'd5, 12'h111);
    step(0, 0, 1, 5'd5, 12'h222);
    check("t6_addr", mem_address, BASE_WORD);
    end_check("t6");

    // Randomized captures; starts while busy and stops while idle are mixed in.
    for (int c = 0; c < 25; c++) begin
      set_cfg($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 5),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)));
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 40; i++)
        step(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 2)),
             12'($urandom_range(0, 4095)));
      step(0, 1, 0, 0, 0);
      end_check("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
